// File: rtl/ex_stage.sv
// ex_stage: execute stage with a registered EX/MEM boundary.
//
// Single-cycle ALU operations (logic, shift, move, arithmetic) are computed
// combinationally and loaded into the output registers at the next edge.
// MULT, MULTU and MUL run on an iterative shift-add multiplier. It raises
// stallreq_o from the accept cycle until the product is ready.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   stall_i               downstream hold; every register keeps its value
//   aluop_i, alusel_i     operation code and result-group select from decode
//   reg1_i, reg2_i        operands
//   wd_i, wreg_i          destination register and its write enable
//   hi_i, lo_i            current (forwarded) HI/LO
//   stallreq_o            combinational request to hold ID and upstream
//   wd_o, wreg_o, wdata_o registered writeback request
//   whilo_o, hi_o, lo_o   registered HI/LO write request
module ex_stage #(
  parameter int MUL_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  output logic        stallreq_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        whilo_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  // Operation codes
  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
  localparam logic [7:0] OP_ADDIU = 8'b0101_0110;
  localparam logic [7:0] OP_CLZ   = 8'b1011_0000;
  localparam logic [7:0] OP_CLO   = 8'b1011_0001;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_MUL   = 8'b1010_1001;

  // Result-group selects
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_ARITH = 3'b100;

  localparam logic [4:0] LAST_STEP = 5'(MUL_STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Leading-zero count, 0..32
  function automatic logic [5:0] count_lead_zeros(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd0;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && !v[i]) begin
        n = n + 6'd1;
      end else begin
        found = 1'b1;
      end
    end
    return n;
  endfunction

  state_t      state_r;
  logic [4:0]  cnt_r;
  logic [63:0] acc_r;
  logic [31:0] mcand_r;
  logic [31:0] mplier_r;
  logic        neg_r;
  logic [7:0]  mop_r;
  logic [4:0]  mwd_r;
  logic        mwreg_r;

  logic        is_mul_s;
  logic        mul_signed_s;
  logic [63:0] prod_s;
  logic [31:0] sum_s;
  logic [31:0] diff_s;
  logic        add_ov_s;
  logic        sub_ov_s;

  logic [31:0] logic_res_s;
  logic [31:0] shift_res_s;
  logic [31:0] move_res_s;
  logic [31:0] arith_res_s;
  logic        op_known_s;
  logic        ov_s;
  logic        whilo_s;
  logic [31:0] hi_s;
  logic [31:0] lo_s;

  logic [4:0]  ex_wd_s;
  logic        ex_wreg_s;
  logic [31:0] ex_wdata_s;
  logic        ex_whilo_s;
  logic [31:0] ex_hi_s;
  logic [31:0] ex_lo_s;

  assign is_mul_s     = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU) || (aluop_i == OP_MUL);
  assign mul_signed_s = (aluop_i != OP_MULTU);

  assign sum_s  = reg1_i + reg2_i;
  assign diff_s = reg1_i - reg2_i;
  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result sign differs from reg1.
  assign add_ov_s = (reg1_i[31] == reg2_i[31]) && (sum_s[31] != reg1_i[31]);
  assign sub_ov_s = (reg1_i[31] != reg2_i[31]) && (diff_s[31] != reg1_i[31]);

  // Signed multiplies accumulate magnitudes; the sign is applied at the end.
  assign prod_s = neg_r ? (~acc_r + 64'd1) : acc_r;

  // Stall the front end while a multiply is being accepted or iterated.
  assign stallreq_o = ((state_r == ST_IDLE) && is_mul_s) || (state_r == ST_BUSY);

  // Per-group single-cycle results decoded from the operation code
  always_comb begin
    logic_res_s = 32'd0;
    shift_res_s = 32'd0;
    move_res_s  = 32'd0;
    arith_res_s = 32'd0;
    op_known_s  = 1'b1;
    ov_s        = 1'b0;
    whilo_s     = 1'b0;
    hi_s        = 32'd0;
    lo_s        = 32'd0;
    case (aluop_i)
      OP_OR:   logic_res_s = reg1_i | reg2_i;
      OP_AND:  logic_res_s = reg1_i & reg2_i;
      OP_XOR:  logic_res_s = reg1_i ^ reg2_i;
      OP_NOR:  logic_res_s = ~(reg1_i | reg2_i);
      OP_SLL:  shift_res_s = reg2_i << reg1_i[4:0];
      OP_SRL:  shift_res_s = reg2_i >> reg1_i[4:0];
      OP_SRA:  shift_res_s = 32'($signed(reg2_i) >>> reg1_i[4:0]);
      OP_MFHI: move_res_s  = hi_i;
      OP_MFLO: move_res_s  = lo_i;
      OP_MOVZ, OP_MOVN: move_res_s = reg1_i;
      OP_MTHI: begin
        whilo_s = 1'b1;
        hi_s    = reg1_i;
        lo_s    = lo_i;
      end
      OP_MTLO: begin
        whilo_s = 1'b1;
        hi_s    = hi_i;
        lo_s    = reg1_i;
      end
      OP_ADD, OP_ADDI: begin
        arith_res_s = sum_s;
        ov_s        = add_ov_s;
      end
      OP_ADDU, OP_ADDIU: arith_res_s = sum_s;
      OP_SUB: begin
        arith_res_s = diff_s;
        ov_s        = sub_ov_s;
      end
      OP_SUBU: arith_res_s = diff_s;
      OP_SLT:  arith_res_s = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
      OP_SLTU: arith_res_s = {31'd0, (reg1_i < reg2_i)};
      OP_CLZ:  arith_res_s = {26'd0, count_lead_zeros(reg1_i)};
      OP_CLO:  arith_res_s = {26'd0, count_lead_zeros(~reg1_i)};
      default: op_known_s = 1'b0;
    endcase
  end

  // Writeback selection; NOP and unknown codes produce an all-zero bubble
  always_comb begin
    ex_wd_s    = 5'd0;
    ex_wreg_s  = 1'b0;
    ex_wdata_s = 32'd0;
    ex_whilo_s = 1'b0;
    ex_hi_s    = 32'd0;
    ex_lo_s    = 32'd0;
    if (op_known_s) begin
      ex_wd_s    = wd_i;
      ex_wreg_s  = wreg_i & ~ov_s;
      ex_whilo_s = whilo_s;
      ex_hi_s    = hi_s;
      ex_lo_s    = lo_s;
      case (alusel_i)
        RES_LOGIC: ex_wdata_s = logic_res_s;
        RES_SHIFT: ex_wdata_s = shift_res_s;
        RES_MOVE:  ex_wdata_s = move_res_s;
        RES_ARITH: ex_wdata_s = arith_res_s;
        default:   ex_wdata_s = 32'd0;
      endcase
    end else begin
      ex_wd_s = 5'd0;
    end
  end

  // Multiplier FSM, accumulator and EX/MEM output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 5'd0;
      acc_r    <= 64'd0;
      mcand_r  <= 32'd0;
      mplier_r <= 32'd0;
      neg_r    <= 1'b0;
      mop_r    <= OP_NOP;
      mwd_r    <= 5'd0;
      mwreg_r  <= 1'b0;
      wd_o     <= 5'd0;
      wreg_o   <= 1'b0;
      wdata_o  <= 32'd0;
      whilo_o  <= 1'b0;
      hi_o     <= 32'd0;
      lo_o     <= 32'd0;
    end else if (!stall_i) begin
      case (state_r)
        ST_IDLE: begin
          if (is_mul_s) begin
            mcand_r  <= (mul_signed_s && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
            mplier_r <= (mul_signed_s && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
            neg_r    <= mul_signed_s & (reg1_i[31] ^ reg2_i[31]);
            mop_r    <= aluop_i;
            mwd_r    <= wd_i;
            mwreg_r  <= wreg_i;
            acc_r    <= 64'd0;
            cnt_r    <= 5'd0;
            state_r  <= ST_BUSY;
            wd_o     <= 5'd0;
            wreg_o   <= 1'b0;
            wdata_o  <= 32'd0;
            whilo_o  <= 1'b0;
            hi_o     <= 32'd0;
            lo_o     <= 32'd0;
          end else begin
            wd_o     <= ex_wd_s;
            wreg_o   <= ex_wreg_s;
            wdata_o  <= ex_wdata_s;
            whilo_o  <= ex_whilo_s;
            hi_o     <= ex_hi_s;
            lo_o     <= ex_lo_s;
          end
        end
        ST_BUSY: begin
          if (mplier_r[cnt_r]) begin
            acc_r <= acc_r + ({32'd0, mcand_r} << cnt_r);
          end
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == LAST_STEP) begin
            state_r <= ST_FIN;
          end
          wd_o    <= 5'd0;
          wreg_o  <= 1'b0;
          wdata_o <= 32'd0;
          whilo_o <= 1'b0;
          hi_o    <= 32'd0;
          lo_o    <= 32'd0;
        end
        ST_FIN: begin
          // The multiply still presented by ID is consumed here, not restarted.
          wd_o <= mwd_r;
          if (mop_r == OP_MUL) begin
            wreg_o  <= mwreg_r;
            wdata_o <= prod_s[31:0];
            whilo_o <= 1'b0;
            hi_o    <= 32'd0;
            lo_o    <= 32'd0;
          end else begin
            wreg_o  <= 1'b0;
            wdata_o <= 32'd0;
            whilo_o <= 1'b1;
            hi_o    <= prod_s[63:32];
            lo_o    <= prod_s[31:0];
          end
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          wd_o    <= 5'd0;
          wreg_o  <= 1'b0;
          wdata_o <= 32'd0;
          whilo_o <= 1'b0;
          hi_o    <= 32'd0;
          lo_o    <= 32'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: randomized single-cycle ops and
// multiplies checked against a behavioural model, plus directed cases for
// overflow, shifts, leading counts, stall and mid-multiply reset.
module tb_ex_stage;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
  localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADD   = 8'b0010_0000;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUB   = 8'b0010_0010;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_ADDI  = 8'b0101_0101;
  localparam logic [7:0] OP_ADDIU = 8'b0101_0110;
  localparam logic [7:0] OP_CLZ   = 8'b1011_0000;
  localparam logic [7:0] OP_CLO   = 8'b1011_0001;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_MUL   = 8'b1010_1001;

  localparam logic [2:0] RES_NOP   = 3'b000;
  localparam logic [2:0] RES_LOGIC = 3'b001;
  localparam logic [2:0] RES_SHIFT = 3'b010;
  localparam logic [2:0] RES_MOVE  = 3'b011;
  localparam logic [2:0] RES_ARITH = 3'b100;
  localparam logic [2:0] RES_MUL   = 3'b101;

  localparam int NOPS = 26;
  localparam logic [7:0] OP_TAB [NOPS] = '{
    OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA, OP_MOVZ, OP_MOVN,
    OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_SLT, OP_SLTU, OP_ADD, OP_ADDU,
    OP_SUB, OP_SUBU, OP_ADDI, OP_ADDIU, OP_CLZ, OP_CLO, OP_NOP, 8'hFF, 8'h77};
  localparam logic [2:0] SEL_TAB [NOPS] = '{
    RES_LOGIC, RES_LOGIC, RES_LOGIC, RES_LOGIC, RES_SHIFT, RES_SHIFT, RES_SHIFT,
    RES_MOVE, RES_MOVE, RES_MOVE, RES_MOVE, RES_NOP, RES_NOP, RES_ARITH,
    RES_ARITH, RES_ARITH, RES_ARITH, RES_ARITH, RES_ARITH, RES_ARITH, RES_ARITH,
    RES_ARITH, RES_ARITH, RES_NOP, RES_ARITH, RES_LOGIC};

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] hi_i;
  logic [31:0] lo_i;
  logic        stallreq_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int checks   = 0;
  int failures = 0;

  ex_stage #(.MUL_STEPS(32)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .hi_i(hi_i), .lo_i(lo_i),
    .stallreq_o(stallreq_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o));

  always #5 clk = ~clk;

  // Behavioural model for the single-cycle operations
  function automatic exp_t ref_single(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] hi, input logic [31:0] lo,
                                      input logic [4:0] wd, input logic wreg);
    exp_t e;
    longint s;
    int n;
    logic [31:0] v;
    e = '0;
    e.wd = wd;
    e.wreg = wreg;
    case (op)
      OP_OR:   e.wdata = a | b;
      OP_AND:  e.wdata = a & b;
      OP_XOR:  e.wdata = a ^ b;
      OP_NOR:  e.wdata = ~(a | b);
      OP_SLL:  e.wdata = b << a[4:0];
      OP_SRL:  e.wdata = b >> a[4:0];
      OP_SRA:  e.wdata = (b >> a[4:0]) | (b[31] ? ~(32'hFFFF_FFFF >> a[4:0]) : 32'd0);
      OP_MFHI: e.wdata = hi;
      OP_MFLO: e.wdata = lo;
      OP_MOVZ, OP_MOVN: e.wdata = a;
      OP_MTHI: begin e.whilo = 1'b1; e.hi = a; e.lo = lo; end
      OP_MTLO: begin e.whilo = 1'b1; e.hi = hi; e.lo = a; end
      OP_ADD, OP_ADDI, OP_SUB: begin
        if (op == OP_SUB) s = longint'(int'(a)) - longint'(int'(b));
        else s = longint'(int'(a)) + longint'(int'(b));
        e.wdata = 32'(s);
        if (s > longint'(32'h7FFF_FFFF) || s < -longint'(32'h8000_0000)) e.wreg = 1'b0;
      end
      OP_ADDU, OP_ADDIU: e.wdata = a + b;
      OP_SUBU: e.wdata = a - b;
      OP_SLT:  e.wdata = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      OP_SLTU: e.wdata = (a < b) ? 32'd1 : 32'd0;
      OP_CLZ, OP_CLO: begin
        v = (op == OP_CLZ) ? a : ~a;
        n = 0;
        while (n < 32 && v[31] == 1'b0) begin v = v << 1; n++; end
        e.wdata = 32'(n);
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Full 64-bit product for the multiply ops
  function automatic logic [63:0] ref_prod(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (op == OP_MULTU) p = {32'd0, a} * {32'd0, b};
    else p = 64'(longint'(int'(a)) * longint'(int'(b)));
    return p;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wd, input logic wreg);
    aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wreg;
  endtask

  // Present a multiply and watch it through; returns observations only
  task automatic run_mul(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wd, input logic wreg,
                         output int scnt, output int bub_bad, output logic timeout, output exp_t got);
    drive(op, RES_MUL, a, b, wd, wreg);
    scnt = 0; bub_bad = 0; timeout = 1'b1;
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (j > 0 && (wreg_o || whilo_o || wdata_o != 32'd0 || hi_o != 32'd0 || lo_o != 32'd0)) bub_bad++;
      if (!stallreq_o) begin timeout = 1'b0; break; end
      scnt++;
    end
    if (!timeout) begin @(posedge clk); #1; end
    got = {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o};
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; hi_i = 32'd0; lo_i = 32'd0;
    drive(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    #12;
    checks++;
    if ({stallreq_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o} !== '0)
      $display("FAIL reset_state got stallreq=%b wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h expected all 0",
               stallreq_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o);
    if ({stallreq_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o} !== '0) failures++;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_alu_directed();
    logic [7:0]  ops [6] = '{OP_ADDU, OP_ADD, OP_SUB, OP_SRA, OP_CLZ, OP_CLO};
    logic [2:0]  sels[6] = '{RES_ARITH, RES_ARITH, RES_ARITH, RES_SHIFT, RES_ARITH, RES_ARITH};
    logic [31:0] as  [6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'd4, 32'h0001_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [6] = '{32'd1, 32'd1, 32'd1, 32'hF000_0000, 32'd0, 32'd0};
    logic [31:0] ew  [6] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFF00_0000, 32'd15, 32'd32};
    logic        er  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], sels[i], as[i], bs[i], 5'd9, 1'b1);
      @(posedge clk); #1;
      checks++;
      if (wdata_o !== ew[i] || wreg_o !== er[i] || wd_o !== 5'd9 || whilo_o !== 1'b0) begin
        failures++;
        $display("FAIL alu_directed[%0d] op=%h got wdata=%h wreg=%b wd=%h whilo=%b expected wdata=%h wreg=%b wd=09 whilo=0",
                 i, ops[i], wdata_o, wreg_o, wd_o, whilo_o, ew[i], er[i]);
      end
    end
  endtask

  task automatic test_alu_random();
    exp_t e, got;
    int idx;
    logic [31:0] a, b;
    for (int i = 0; i < 120; i++) begin
      idx = $urandom_range(0, NOPS - 1);
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 4))
        0: begin a = 32'h7FFF_FFFF - 32'($urandom_range(0, 3)); b = 32'($urandom_range(0, 8)); end
        1: begin a = 32'h8000_0000 + 32'($urandom_range(0, 3)); b = 32'h8000_0000 + 32'($urandom_range(0, 3)); end
        2: a = a >> $urandom_range(0, 31);
        3: a = ~(a >> $urandom_range(0, 31));
        default: b = b;
      endcase
      hi_i = $urandom; lo_i = $urandom;
      drive(OP_TAB[idx], SEL_TAB[idx], a, b, 5'($urandom), 1'($urandom));
      e = ref_single(OP_TAB[idx], a, b, hi_i, lo_i, wd_i, wreg_i);
      @(posedge clk); #1;
      got = {wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o};
      checks++;
      if (got !== e || stallreq_o !== 1'b0) begin
        failures++;
        $display("FAIL alu_random op=%h a=%h b=%h got wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h stallreq=%b expected wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h stallreq=0",
                 OP_TAB[idx], a, b, got.wd, got.wreg, got.wdata, got.whilo, got.hi, got.lo, stallreq_o,
                 e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo);
      end
    end
  endtask

  // MULT, then MULTU and MUL each accepted in the cycle right after FIN
  task automatic test_back_to_back();
    int scnt, bub; logic to; exp_t got;
    run_mul(OP_MULT, 32'hFFFF_FFFD, 32'd7, 5'd3, 1'b1, scnt, bub, to, got);
    checks++;
    if (to || scnt != 33 || bub != 0 || got.whilo !== 1'b1 || got.hi !== 32'hFFFF_FFFF ||
        got.lo !== 32'hFFFF_FFEB || got.wreg !== 1'b0) begin
      failures++;
      $display("FAIL mult_neg3x7 got timeout=%b stall_cycles=%0d bubbles_bad=%0d whilo=%b hi=%h lo=%h wreg=%b expected 0 33 0 1 ffffffff ffffffeb 0",
               to, scnt, bub, got.whilo, got.hi, got.lo, got.wreg);
    end
    run_mul(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0, scnt, bub, to, got);
    checks++;
    if (to || scnt != 33 || bub != 0 || got.whilo !== 1'b1 || got.hi !== 32'hFFFF_FFFE ||
        got.lo !== 32'h0000_0001 || got.wreg !== 1'b0) begin
      failures++;
      $display("FAIL multu_max got timeout=%b stall_cycles=%0d bubbles_bad=%0d whilo=%b hi=%h lo=%h wreg=%b expected 0 33 0 1 fffffffe 00000001 0",
               to, scnt, bub, got.whilo, got.hi, got.lo, got.wreg);
    end
    run_mul(OP_MUL, 32'd6, 32'd7, 5'd5, 1'b1, scnt, bub, to, got);
    checks++;
    if (to || scnt != 33 || bub != 0 || got.wdata !== 32'd42 || got.wreg !== 1'b1 ||
        got.wd !== 5'd5 || got.whilo !== 1'b0) begin
      failures++;
      $display("FAIL mul_6x7 got timeout=%b stall_cycles=%0d bubbles_bad=%0d wdata=%0d wreg=%b wd=%0d whilo=%b expected 0 33 0 42 1 5 0",
               to, scnt, bub, got.wdata, got.wreg, got.wd, got.whilo);
    end
    drive(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_mult_random();
    int scnt, bub; logic to; exp_t got;
    logic [7:0] op; logic [31:0] a, b; logic [63:0] p; logic [4:0] wd; logic wr; logic ok;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0: op = OP_MULT;
        1: op = OP_MULTU;
        default: op = OP_MUL;
      endcase
      a = (i == 0) ? 32'h8000_0000 : 32'($urandom);
      b = (i == 1) ? 32'h8000_0000 : 32'($urandom);
      wd = 5'($urandom); wr = 1'($urandom);
      p = ref_prod(op, a, b);
      run_mul(op, a, b, wd, wr, scnt, bub, to, got);
      if (op == OP_MUL) ok = (got.wdata === p[31:0]) && (got.wreg === wr) && (got.wd === wd) && (got.whilo === 1'b0);
      else ok = (got.hi === p[63:32]) && (got.lo === p[31:0]) && (got.whilo === 1'b1) && (got.wreg === 1'b0);
      checks++;
      if (to || scnt != 33 || bub != 0 || !ok) begin
        failures++;
        $display("FAIL mult_random op=%h a=%h b=%h got timeout=%b stall_cycles=%0d hi=%h lo=%h wdata=%h wreg=%b whilo=%b expected product=%h stall_cycles=33",
                 op, a, b, to, scnt, got.hi, got.lo, got.wdata, got.wreg, got.whilo, p);
      end
    end
    drive(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
  endtask

  // Three stalled cycles in BUSY and two in FIN push the result to edge 39
  task automatic test_stall();
    logic [31:0] a, b; logic [63:0] p; int first, sr_bad;
    a = $urandom; b = $urandom;
    p = ref_prod(OP_MULT, a, b);
    drive(OP_MULT, RES_MUL, a, b, 5'd7, 1'b0);
    first = 0; sr_bad = 0;
    for (int k = 1; k <= 60; k++) begin
      stall_i = (k == 5 || k == 6 || k == 7 || k == 37 || k == 38);
      #4;
      if (stallreq_o !== (k <= 36)) sr_bad++;
      @(posedge clk); #1;
      if (whilo_o === 1'b1) begin first = k; break; end
    end
    stall_i = 1'b0;
    checks++;
    if (first != 39 || sr_bad != 0 || hi_o !== p[63:32] || lo_o !== p[31:0]) begin
      failures++;
      $display("FAIL mult_stall got result_edge=%0d stallreq_bad=%0d hi=%h lo=%h expected 39 0 %h %h",
               first, sr_bad, hi_o, lo_o, p[63:32], p[31:0]);
    end
    drive(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] lo_v;
    drive(OP_MULT, RES_MUL, 32'($urandom), 32'($urandom), 5'd2, 1'b0);
    repeat (11) @(posedge clk);
    #2;
    checks++;
    if (stallreq_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_busy got stallreq=%b expected 1", stallreq_o);
    end
    lo_v = $urandom;
    rst = 1'b1;
    lo_i = lo_v;
    drive(OP_MTHI, RES_NOP, 32'h0000_1234, 32'd0, 5'd0, 1'b0);
    #1;
    checks++;
    if ({stallreq_o, wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o} !== '0) begin
      failures++;
      $display("FAIL reset_mid_async got stallreq=%b whilo=%b hi=%h lo=%h wdata=%h expected all 0",
               stallreq_o, whilo_o, hi_o, lo_o, wdata_o);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (whilo_o !== 1'b1 || hi_o !== 32'h0000_1234 || lo_o !== lo_v || stallreq_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_mthi got whilo=%b hi=%h lo=%h stallreq=%b expected 1 00001234 %h 0",
               whilo_o, hi_o, lo_o, stallreq_o, lo_v);
    end
    drive(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_alu_directed();
    test_alu_random();
    test_back_to_back();
    test_mult_random();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage with a registered EX/MEM boundary. It consumes the decode stage's operation code, result-select, operands and destination. It produces registered writeback data plus HI/LO write requests for the memory stage. Single-cycle ALU operations complete in one cycle. MULT, MULTU and MUL run on an iterative 32-step shift-add multiplier that raises `stallreq_o` until the product is ready.

## Interface
Parameters:
- `MUL_STEPS`, default 32: number of shift-add iterations. It is fixed at 32 and exists for bench visibility only.

Ports:
- `clk`, input, 1: clock. Single clock domain.
- `rst`, input, 1: reset. Asynchronous, active-high.
- `stall_i`, input, 1: downstream hold. When set, every register in the block holds its value.
- `aluop_i`, input, 8: `EXE_*_OP` code.
- `alusel_i`, input, 3: `EXE_RES_*` result select.
- `reg1_i`, input, 32: operand 1 (rs or immediate).
- `reg2_i`, input, 32: operand 2 (rt or immediate).
- `wd_i`, input, 5: destination register.
- `wreg_i`, input, 1: destination write enable.
- `hi_i`, input, 32: current HI (already forwarded).
- `lo_i`, input, 32: current LO (already forwarded).
- `stallreq_o`, output, 1: combinational request to hold ID and the stages upstream of it.
- `wd_o`, output, 5: registered destination register.
- `wreg_o`, output, 1: registered write enable.
- `wdata_o`, output, 32: registered writeback data.
- `whilo_o`, output, 1: registered HI/LO write enable.
- `hi_o`, output, 32: registered HI write value.
- `lo_o`, output, 32: registered LO write value.

## Operation
- FSM states: IDLE, BUSY, FIN.
- Single-cycle ops are those in IDLE whose `aluop_i` is not MULT, MULTU or MUL. The result is computed combinationally and loaded into the output registers at the next edge. `wd_o` = `wd_i`.
- LOGIC: OR, AND, XOR, NOR of reg1 and reg2.
- SHIFT: SLL, SRL, SRA of reg2 by reg1[4:0]. SRA sign-fills.
- MOVE:
  - MFHI gives `hi_i`; MFLO gives `lo_i`.
  - MOVZ and MOVN give reg1. `wreg_i` is passed through unchanged.
  - MTHI: `whilo_o`=1, `hi_o`=reg1, `lo_o`=`lo_i`.
  - MTLO: `whilo_o`=1, `hi_o`=`hi_i`, `lo_o`=reg1.
- ARITHMETIC:
  - ADD, ADDU, ADDI and ADDIU compute reg1+reg2 mod 2^32.
  - SUB and SUBU compute reg1−reg2.
  - SLT is a signed compare and SLTU an unsigned compare, each giving 0 or 1.
  - CLZ and CLO count leading zeros/ones of reg1, from 0 to 32.
  - On signed overflow in ADD, ADDI or SUB, `wreg_o` is forced to 0 and `wdata_o` still carries the wrapped sum.
- NOP or unknown op: all outputs load 0.
- Multiply accept: IDLE with a MULT, MULTU or MUL op.
  - `stallreq_o` goes to 1.
  - At the edge the block latches the operand magnitudes, the product sign (signed ops only: reg1[31]^reg2[31]), the op, `wd_i` and `wreg_i`.
  - Product accumulator is cleared, counter is set to 0, and the FSM moves to BUSY.
  - Output registers load a bubble (all 0).
- BUSY:
  - Each cycle, if multiplier bit[cnt] is set, add multiplicand<<cnt into the 64-bit accumulator; then cnt++.
  - `stallreq_o`=1 and the output registers load bubbles.
  - The edge with cnt==31 moves the FSM to FIN.
- FIN:
  - `stallreq_o`=0. ID is still presenting the same multiply op; it is consumed as complete and not restarted.
  - The product is negated (64-bit two's complement) if the sign flag is set.
  - MULT and MULTU: `whilo_o`=1, `hi_o`=product[63:32], `lo_o`=product[31:0], `wreg_o`=0.
  - MUL: `wreg_o`=latched `wreg_i`, `wdata_o`=product[31:0], `whilo_o`=0.
  - The FSM then returns to IDLE.
- `stall_i`=1: FSM, counter, accumulator and output registers all hold. `stallreq_o` follows the held state.

## Timing
- Reset state: every output is 0 and `stallreq_o`=0. FSM is in IDLE, counter and accumulator are 0. Reset is asynchronous.
- Single-cycle op: presented in cycle N, visible on the outputs after edge N+1.
- Multiply:
  - Accept cycle A, then 32 BUSY cycles, then FIN; 34 cycles in total with no stalls.
  - `stallreq_o` is high for exactly 33 cycles (A plus BUSY).
  - Result is visible after the FIN edge.
- Back-to-back multiplies: the second one is accepted in the cycle after FIN. No gap beyond the normal IDLE accept.
- Reset asserted mid-multiply: the operation aborts, the FSM goes to IDLE, outputs return to 0 and `stallreq_o` drops immediately.
- `stall_i` during BUSY extends the latency one cycle per stalled cycle. The accumulator value is preserved.
- `stall_i` during FIN holds FIN; the result loads on the first cycle with `stall_i`=0.

## Test plan
- ADDU 0x7FFFFFFF + 1 → `wdata_o`=0x80000000, `wreg_o`=1. ADD with the same operands → `wreg_o`=0.
- SRA by reg1=4 of reg2=0xF0000000 → 0xFF000000. CLZ of 0x00010000 → 15. CLO of 0xFFFFFFFF → 32.
- MULT −3 × 7 → `stallreq_o` high 33 cycles, then `whilo_o`=1, `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi_o`=0xFFFFFFFE, `lo_o`=0x00000001. MUL 6 × 7 to wd=5 → `wdata_o`=42, `wreg_o`=1, `whilo_o`=0.
- MULT with `stall_i` high for 3 cycles in BUSY and 2 in FIN → result appears 5 cycles late, value unchanged.
- Reset pulsed at BUSY cnt=10, then MTHI 0x1234 → `stallreq_o` drops at once; next edge gives `whilo_o`=1, `hi_o`=0x1234, `lo_o`=`lo_i`.
